// File: rtl/frame_buffer_ctrl.sv
// Ping-pong frame-buffer controller. The camera pixel stream is steered into one of two
// RAM banks, and only whole frames are handed to the consumer through a valid/ack handshake.
module frame_buffer_ctrl #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FRAME_PIXELS = 9216
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Enable,
  input  logic              i_Cam_VS,
  input  logic              i_Pix_Valid,
  input  logic [DATA_W-1:0] i_Pix_Data,
  output logic [1:0]        o_Bank_We,
  output logic [ADDR_W-1:0] o_Bank_Addr,
  output logic [DATA_W-1:0] o_Bank_Data,
  output logic              o_Rd_Bank,
  output logic              o_Frame_Valid,
  input  logic              i_Frame_Ack,
  output logic              o_Frame_Err,
  output logic [7:0]        o_Frames_Dropped
);

  // One extra bit so a full count is representable even when FRAME_PIXELS == 2**ADDR_W.
  localparam int unsigned    CntW     = ADDR_W + 1;
  localparam logic [CntW-1:0] FrameLen = CntW'(FRAME_PIXELS);

  typedef enum logic [1:0] {StArm, StBlank, StCapture, StHold} state_e;

  state_e              state_q, state_d;
  logic                vs_q;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [CntW-1:0]     pix_cnt_q, pix_cnt_d;
  logic                long_q, long_d;
  logic                pending_q, pending_d;
  logic                frame_valid_q, frame_valid_d;
  logic                frame_err_q, frame_err_d;
  logic [7:0]          dropped_q, dropped_d;
  logic [1:0]          we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic vs_fall, vs_rise, ack;

  assign vs_fall = vs_q & ~i_Cam_VS;
  assign vs_rise = ~vs_q & i_Cam_VS;
  // An ack only counts while a frame is actually being offered.
  assign ack     = i_Frame_Ack & frame_valid_q;

  // Next-state logic: consumer handshake first, then the writer FSM (so a same-cycle ack
  // frees the read bank before a commit swaps into it).
  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    pix_cnt_d     = pix_cnt_q;
    long_d        = long_q;
    pending_d     = pending_q;
    frame_valid_d = frame_valid_q;
    frame_err_d   = 1'b0;
    dropped_d     = dropped_q;
    we_d          = 2'b00;
    addr_d        = addr_q;
    data_d        = data_q;

    if (ack) begin
      if (pending_q) begin
        rd_bank_d = wr_bank_q;
        wr_bank_d = ~wr_bank_q;
        pending_d = 1'b0;
      end else begin
        frame_valid_d = 1'b0;
      end
    end

    unique case (state_q)
      StArm: begin
        // Entering through blanking guarantees capture never starts mid-frame.
        if (i_Enable && i_Cam_VS) state_d = StBlank;
      end
      StBlank: begin
        if (vs_fall) begin
          state_d   = StCapture;
          pix_cnt_d = '0;
          long_d    = 1'b0;
        end
      end
      StCapture: begin
        if (i_Pix_Valid) begin
          if (pix_cnt_q < FrameLen) begin
            we_d[wr_bank_q] = 1'b1;
            addr_d          = pix_cnt_q[ADDR_W-1:0];
            data_d          = i_Pix_Data;
            pix_cnt_d       = pix_cnt_q + 1'b1;
          end else begin
            long_d = 1'b1;
          end
        end
        if (vs_rise) begin
          if (pix_cnt_q != FrameLen || long_q) begin
            frame_err_d = 1'b1;
            state_d     = StArm;
          end else if (!frame_valid_q || ack) begin
            rd_bank_d     = wr_bank_q;
            wr_bank_d     = ~wr_bank_q;
            frame_valid_d = 1'b1;
            state_d       = StArm;
          end else begin
            // Reader still busy: keep wr_bank so the finished frame survives.
            pending_d = 1'b1;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (vs_fall && dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
        if (ack) state_d = StArm;
      end
      default: state_d = StArm;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q       <= StArm;
      vs_q          <= 1'b1;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      pix_cnt_q     <= '0;
      long_q        <= 1'b0;
      pending_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      dropped_q     <= 8'd0;
      we_q          <= 2'b00;
      addr_q        <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      vs_q          <= i_Cam_VS;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      pix_cnt_q     <= pix_cnt_d;
      long_q        <= long_d;
      pending_q     <= pending_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      dropped_q     <= dropped_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
    end
  end

  assign o_Bank_We        = we_q;
  assign o_Bank_Addr      = addr_q;
  assign o_Bank_Data      = data_q;
  assign o_Rd_Bank        = rd_bank_q;
  assign o_Frame_Valid    = frame_valid_q;
  assign o_Frame_Err      = frame_err_q;
  assign o_Frames_Dropped = dropped_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl: whole frames, short/long frames, pending hold with
// dropped-frame counting and saturation, ack coincident with commit, reset mid-frame.
`timescale 1ns/1ps
module tb_frame_buffer_ctrl;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FP     = 9216;

  logic              i_Clk = 1'b0;
  logic              i_Rst;
  logic              i_Enable;
  logic              i_Cam_VS;
  logic              i_Pix_Valid;
  logic [DATA_W-1:0] i_Pix_Data;
  logic [1:0]        o_Bank_We;
  logic [ADDR_W-1:0] o_Bank_Addr;
  logic [DATA_W-1:0] o_Bank_Data;
  logic              o_Rd_Bank;
  logic              o_Frame_Valid;
  logic              i_Frame_Ack;
  logic              o_Frame_Err;
  logic [7:0]        o_Frames_Dropped;

  int checks   = 0;
  int failures = 0;

  // Write monitor state (written only by the monitor process).
  int wr_cnt0 = 0, wr_cnt1 = 0, bad_we = 0, bad_seq = 0, bad_data = 0, last_addr = -1;
  // Snapshots (written only by the main process).
  int s_cnt0, s_cnt1, s_we, s_seq, s_data;

  frame_buffer_ctrl #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .FRAME_PIXELS (FP)
  ) dut (
    .i_Clk            (i_Clk),
    .i_Rst            (i_Rst),
    .i_Enable         (i_Enable),
    .i_Cam_VS         (i_Cam_VS),
    .i_Pix_Valid      (i_Pix_Valid),
    .i_Pix_Data       (i_Pix_Data),
    .o_Bank_We        (o_Bank_We),
    .o_Bank_Addr      (o_Bank_Addr),
    .o_Bank_Data      (o_Bank_Data),
    .o_Rd_Bank        (o_Rd_Bank),
    .o_Frame_Valid    (o_Frame_Valid),
    .i_Frame_Ack      (i_Frame_Ack),
    .o_Frame_Err      (o_Frame_Err),
    .o_Frames_Dropped (o_Frames_Dropped)
  );

  always #5 i_Clk = ~i_Clk;

  // Track bank writes on the falling edge; addresses must run consecutively from 0.
  always @(negedge i_Clk) begin
    if (o_Bank_We != 2'b00) begin
      if (o_Bank_We == 2'b01)      wr_cnt0 <= wr_cnt0 + 1;
      else if (o_Bank_We == 2'b10) wr_cnt1 <= wr_cnt1 + 1;
      else                         bad_we  <= bad_we + 1;
      if (o_Bank_Addr != '0 && int'(o_Bank_Addr) != last_addr + 1) bad_seq <= bad_seq + 1;
      if (o_Bank_Data !== (o_Bank_Addr[7:0] ^ 8'h5A)) bad_data <= bad_data + 1;
      last_addr <= int'(o_Bank_Addr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic snap();
    s_cnt0 = wr_cnt0;
    s_cnt1 = wr_cnt1;
    s_we   = bad_we;
    s_seq  = bad_seq;
    s_data = bad_data;
  endtask

  task automatic chk_writes(input string tag, input int n0, input int n1);
    chk({tag, "_bank0_writes"}, wr_cnt0 - s_cnt0, n0);
    chk({tag, "_bank1_writes"}, wr_cnt1 - s_cnt1, n1);
    chk({tag, "_addr_seq"}, (bad_seq - s_seq) + (bad_we - s_we), 0);
    chk({tag, "_data"}, bad_data - s_data, 0);
  endtask

  // Blanking, VS fall, npix pixels, VS rise (optionally with ack on the rise cycle).
  task automatic frame(input int npix, input bit ack_at_rise);
    i_Cam_VS = 1'b1;
    repeat (3) tick();
    i_Cam_VS = 1'b0;
    tick();
    for (int i = 0; i < npix; i++) begin
      i_Pix_Valid = 1'b1;
      i_Pix_Data  = i[7:0] ^ 8'h5A;
      tick();
    end
    i_Pix_Valid = 1'b0;
    tick();
    tick();
    i_Cam_VS    = 1'b1;
    i_Frame_Ack = ack_at_rise;
    tick();
    i_Frame_Ack = 1'b0;
  endtask

  task automatic do_ack();
    i_Frame_Ack = 1'b1;
    tick();
    i_Frame_Ack = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, int'(o_Bank_We), 0);
    chk({tag, "_addr"}, int'(o_Bank_Addr), 0);
    chk({tag, "_data"}, int'(o_Bank_Data), 0);
    chk({tag, "_rd_bank"}, int'(o_Rd_Bank), 1);
    chk({tag, "_valid"}, int'(o_Frame_Valid), 0);
    chk({tag, "_err"}, int'(o_Frame_Err), 0);
    chk({tag, "_dropped"}, int'(o_Frames_Dropped), 0);
  endtask

  initial begin
    i_Rst       = 1'b1;
    i_Enable    = 1'b0;
    i_Cam_VS    = 1'b1;
    i_Pix_Valid = 1'b0;
    i_Pix_Data  = '0;
    i_Frame_Ack = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    i_Rst    = 1'b0;
    i_Enable = 1'b1;
    tick();

    // Full frame lands in bank0 and is offered one cycle after the VS rise.
    snap();
    frame(FP, 1'b0);
    chk("t1_valid", int'(o_Frame_Valid), 1);
    chk("t1_rd_bank", int'(o_Rd_Bank), 0);
    chk("t1_err", int'(o_Frame_Err), 0);
    chk_writes("t1", FP, 0);
    chk("t1_last_addr", last_addr, FP - 1);

    // Ack coincident with commit: bank1 frame swaps in, valid stays high.
    snap();
    frame(FP, 1'b1);
    chk("t4_valid", int'(o_Frame_Valid), 1);
    chk("t4_rd_bank", int'(o_Rd_Bank), 1);
    chk_writes("t4", 0, FP);
    do_ack();
    chk("t4_ack_valid", int'(o_Frame_Valid), 0);
    chk("t4_ack_rd_bank", int'(o_Rd_Bank), 1);

    // Short frame (writes bank0) is rejected with a single error pulse.
    snap();
    frame(9000, 1'b0);
    chk("t2s_err_pulse", int'(o_Frame_Err), 1);
    chk("t2s_valid", int'(o_Frame_Valid), 0);
    chk_writes("t2s", 9000, 0);
    chk("t2s_last_addr", last_addr, 8999);
    tick();
    chk("t2s_err_clear", int'(o_Frame_Err), 0);
    chk("t2s_rd_bank", int'(o_Rd_Bank), 1);

    // Long frame: only 0..FP-1 written, then rejected.
    snap();
    frame(FP + 1, 1'b0);
    chk("t2l_err_pulse", int'(o_Frame_Err), 1);
    chk("t2l_valid", int'(o_Frame_Valid), 0);
    chk_writes("t2l", FP, 0);
    chk("t2l_last_addr", last_addr, FP - 1);
    tick();
    chk("t2l_err_clear", int'(o_Frame_Err), 0);

    // Commit to bank0, then an unacked bank1 frame goes pending.
    snap();
    frame(FP, 1'b0);
    chk("t3a_rd_bank", int'(o_Rd_Bank), 0);
    chk("t3a_valid", int'(o_Frame_Valid), 1);
    frame(FP, 1'b0);
    chk("t3b_rd_bank", int'(o_Rd_Bank), 0);
    chk("t3b_valid", int'(o_Frame_Valid), 1);
    chk("t3b_err", int'(o_Frame_Err), 0);
    chk_writes("t3ab", FP, FP);

    // Two frames start while held: counted as dropped, nothing written.
    snap();
    frame(50, 1'b0);
    frame(50, 1'b0);
    chk("t3_dropped", int'(o_Frames_Dropped), 2);
    chk_writes("t3_hold", 0, 0);

    // Saturation: 255 drops total, then 45 more.
    for (int i = 0; i < 253; i++) begin
      i_Cam_VS = 1'b0;
      tick();
      i_Cam_VS = 1'b1;
      tick();
    end
    chk("t6_dropped_255", int'(o_Frames_Dropped), 255);
    for (int i = 0; i < 45; i++) begin
      i_Cam_VS = 1'b0;
      tick();
      i_Cam_VS = 1'b1;
      tick();
    end
    chk("t6_dropped_sat", int'(o_Frames_Dropped), 255);

    // Ack releases the pending bank1 frame.
    do_ack();
    chk("t3_ack_rd_bank", int'(o_Rd_Bank), 1);
    chk("t3_ack_valid", int'(o_Frame_Valid), 1);
    chk("t3_ack_dropped", int'(o_Frames_Dropped), 255);

    // Reset at pixel 5000 of a frame.
    i_Cam_VS = 1'b1;
    repeat (3) tick();
    i_Cam_VS = 1'b0;
    tick();
    for (int i = 0; i < 5000; i++) begin
      i_Pix_Valid = 1'b1;
      i_Pix_Data  = i[7:0] ^ 8'h5A;
      tick();
    end
    i_Rst       = 1'b1;
    i_Pix_Valid = 1'b0;
    #1;
    chk_reset_outputs("t5_async");
    tick();
    i_Rst = 1'b0;
    tick();
    snap();
    frame(FP, 1'b0);
    chk("t5_rd_bank", int'(o_Rd_Bank), 0);
    chk("t5_valid", int'(o_Frame_Valid), 1);
    chk("t5_dropped", int'(o_Frames_Dropped), 0);
    chk_writes("t5", FP, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
